// File: rtl/quad_decoder_4bit.sv
// quad_decoder_4bit: glitch-filtered quadrature decoder driving a 4-bit position counter.
// Each channel passes through a two-flop synchronizer and then a per-channel level filter.
// After reset a short PRIME phase seeds the filters. The RUN phase then decodes Gray-code
// steps into count/dir/step and flags double-bit jumps on err.
module quad_decoder_4bit #(
  parameter int unsigned FILTER_LEN = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       a_in,
  input  logic       b_in,
  input  logic       en,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       clr_err,
  output logic [3:0] count,
  output logic       dir,
  output logic       step,
  output logic       err
);

  // Filter counter value on the last disagreeing cycle before the new level is accepted.
  localparam logic [3:0] FltLast = 4'(FILTER_LEN - 1);

  typedef enum logic [0:0] {StPrime, StRun} state_e;

  state_e     state_q;
  logic       prime_cnt_q;

  // Synchronizer stages.
  logic       a_meta_q, b_meta_q;
  logic       a_s_q, b_s_q;

  // Filtered levels and their agreement counters.
  logic       a_f_q, b_f_q;
  logic [3:0] a_cnt_q, b_cnt_q;
  logic       a_f_d, b_f_d;
  logic [3:0] a_cnt_d, b_cnt_d;

  // Filtered {A,B} seen on the previous edge.
  logic [1:0] ab_prev_q;
  logic [1:0] ab_cur;

  logic       is_up, is_down, is_illegal;

  assign ab_cur = {a_f_q, b_f_q};

  // Level filters: accept the synchronized level after FILTER_LEN consecutive disagreeing cycles.
  always_comb begin
    a_f_d   = a_f_q;
    a_cnt_d = '0;
    if (a_s_q != a_f_q) begin
      if (a_cnt_q == FltLast) begin
        a_f_d = a_s_q;
      end else begin
        a_cnt_d = a_cnt_q + 4'd1;
      end
    end

    b_f_d   = b_f_q;
    b_cnt_d = '0;
    if (b_s_q != b_f_q) begin
      if (b_cnt_q == FltLast) begin
        b_f_d = b_s_q;
      end else begin
        b_cnt_d = b_cnt_q + 4'd1;
      end
    end
  end

  // Classify the previous->current filtered pair; up is 00->01->11->10->00.
  always_comb begin
    is_up   = 1'b0;
    is_down = 1'b0;
    unique case ({ab_prev_q, ab_cur})
      4'b0001, 4'b0111, 4'b1110, 4'b1000: is_up   = 1'b1;
      4'b0010, 4'b1011, 4'b1101, 4'b0100: is_down = 1'b1;
      default: ;
    endcase
    is_illegal = ((ab_prev_q ^ ab_cur) == 2'b11);
  end

  // Synchronizers, filters, PRIME/RUN sequencing and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StPrime;
      prime_cnt_q <= 1'b0;
      a_meta_q    <= 1'b0;
      b_meta_q    <= 1'b0;
      a_s_q       <= 1'b0;
      b_s_q       <= 1'b0;
      a_f_q       <= 1'b0;
      b_f_q       <= 1'b0;
      a_cnt_q     <= '0;
      b_cnt_q     <= '0;
      ab_prev_q   <= 2'b00;
      count       <= 4'd0;
      dir         <= 1'b0;
      step        <= 1'b0;
      err         <= 1'b0;
    end else begin
      a_meta_q <= a_in;
      b_meta_q <= b_in;
      a_s_q    <= a_meta_q;
      b_s_q    <= b_meta_q;
      step     <= 1'b0;

      case (state_q)
        StPrime: begin
          // Load the value a_s is taking on this edge, so after each edge the filtered level
          // and the history equal the synchronizer output and RUN starts with no phantom edge.
          a_f_q       <= a_meta_q;
          b_f_q       <= b_meta_q;
          ab_prev_q   <= {a_meta_q, b_meta_q};
          a_cnt_q     <= '0;
          b_cnt_q     <= '0;
          prime_cnt_q <= 1'b1;
          if (prime_cnt_q) begin
            state_q <= StRun;
          end
        end

        StRun: begin
          a_f_q     <= a_f_d;
          b_f_q     <= b_f_d;
          a_cnt_q   <= a_cnt_d;
          b_cnt_q   <= b_cnt_d;
          // History always tracks, even with en low, so re-enabling never sees a stale step.
          ab_prev_q <= ab_cur;

          if (load) begin
            count <= load_val;
          end else if (en && is_up) begin
            count <= count + 4'd1;
            dir   <= 1'b1;
            step  <= 1'b1;
          end else if (en && is_down) begin
            count <= count - 4'd1;
            dir   <= 1'b0;
            step  <= 1'b1;
          end

          // A new illegal jump beats a simultaneous clear.
          if (en && is_illegal) begin
            err <= 1'b1;
          end else if (clr_err) begin
            err <= 1'b0;
          end
        end

        default: begin
          state_q <= StPrime;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_quad_decoder_4bit.sv
// tb_quad_decoder_4bit: table-driven stimulus with a step scoreboard for quad_decoder_4bit.
module tb_quad_decoder_4bit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       a_in = 1'b0;
  logic       b_in = 1'b0;
  logic       en = 1'b1;
  logic       load = 1'b0;
  logic [3:0] load_val = 4'd0;
  logic       clr_err = 1'b0;
  logic [3:0] count;
  logic       dir;
  logic       step;
  logic       err;

  quad_decoder_4bit #(.FILTER_LEN(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .a_in     (a_in),
    .b_in     (b_in),
    .en       (en),
    .load     (load),
    .load_val (load_val),
    .clr_err  (clr_err),
    .count    (count),
    .dir      (dir),
    .step     (step),
    .err      (err)
  );

  always #5 clk = ~clk;

  // Edge counter: after edge k (sampled #1 later) cyc == k.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  // Step latency with FILTER_LEN=2: change driven after edge k is first sampled at k+1,
  // so the step lands on edge k+1+2+2.
  localparam int StepLat = 5;

  typedef struct {
    int         edge_no;
    logic [3:0] cnt;
    logic       dir;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  typedef struct {
    logic       a;
    logic       b;
    logic       en;
    logic       ld;
    logic [3:0] ld_val;
    logic       clr;
    logic       stp;
    logic [3:0] cnt;
    logic       dr;
    logic       er;
    int         hold;
  } vec_t;

  localparam int NumVec = 9;
  vec_t vecs[NumVec];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ab(input logic a, input logic b, input logic exp_step,
                          input logic [3:0] c, input logic d);
    exp_t e;
    a_in = a;
    b_in = b;
    if (exp_step) begin
      e.edge_no = cyc + StepLat;
      e.cnt     = c;
      e.dir     = d;
      sb.push_back(e);
    end
  endtask

  // Monitor: every step pulse must match the oldest expected step, on its edge.
  always @(posedge clk) begin
    #1;
    if (step) begin
      if (sb.size() == 0) begin
        check("step_spurious", int'(step), 0);
      end else begin
        mon_e = sb.pop_front();
        check("step_edge", cyc, mon_e.edge_no);
        check("step_count", int'(count), int'(mon_e.cnt));
        check("step_dir", int'(dir), int'(mon_e.dir));
      end
    end
    if (sb.size() > 0 && sb[0].edge_no < cyc) begin
      check("step_missing", int'(step), 1);
      void'(sb.pop_front());
    end
  end

  initial begin
    //          a     b     en    ld    ldv    clr   stp   cnt     dir   err  hold
    vecs[0] = '{1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 4'd1,  1'b1, 1'b0, 6};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 4'd2,  1'b1, 1'b0, 6};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 4'd3,  1'b1, 1'b0, 6};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 4'd4,  1'b1, 1'b0, 6};
    // load 0 then one down step: wrap to 15
    vecs[4] = '{1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 1'b1, 4'd15, 1'b0, 1'b0, 6};
    // up from 15 wraps to 0
    vecs[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 4'd0,  1'b1, 1'b0, 6};
    // 00 -> 11 is illegal: err set, count and dir held
    vecs[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0,  1'b1, 1'b1, 6};
    // clear err, then keep stepping up
    vecs[7] = '{1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 1'b1, 1'b1, 4'd1,  1'b1, 1'b0, 6};
    vecs[8] = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 4'd2,  1'b1, 1'b0, 6};

    // Reset state, valid from the first edge.
    rst = 1'b1;
    tick();
    check("rst_count", int'(count), 0);
    check("rst_dir", int'(dir), 0);
    check("rst_step", int'(step), 0);
    check("rst_err", int'(err), 0);
    tick();
    rst = 1'b0;
    repeat (6) tick();
    check("idle_count", int'(count), 0);

    for (int i = 0; i < NumVec; i++) begin
      if (vecs[i].ld) begin
        load = 1'b1;
        load_val = vecs[i].ld_val;
        tick();
        load = 1'b0;
        check($sformatf("row%0d_load", i), int'(count), int'(vecs[i].ld_val));
      end
      if (vecs[i].clr) begin
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check($sformatf("row%0d_clr", i), int'(err), 0);
      end
      en = vecs[i].en;
      drive_ab(vecs[i].a, vecs[i].b, vecs[i].stp, vecs[i].cnt, vecs[i].dr);
      repeat (vecs[i].hold) tick();
      check($sformatf("row%0d_count", i), int'(count), int'(vecs[i].cnt));
      check($sformatf("row%0d_dir", i), int'(dir), int'(vecs[i].dr));
      check($sformatf("row%0d_err", i), int'(err), int'(vecs[i].er));
    end

    // One-cycle glitch on A is shorter than the filter: no step.
    a_in = 1'b1;
    tick();
    a_in = 1'b0;
    repeat (8) tick();
    check("glitch_count", int'(count), 2);

    // Partially filtered 11 aborted by reset, inputs held at 11 through reset and PRIME.
    drive_ab(1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    check("midrst_count", int'(count), 0);
    check("midrst_step", int'(step), 0);
    check("midrst_err", int'(err), 0);
    tick();
    rst = 1'b0;
    tick();
    check("prime_count", int'(count), 0);
    repeat (6) tick();
    check("post_prime_err", int'(err), 0);
    check("post_prime_count", int'(count), 0);
    check("post_prime_dir", int'(dir), 0);
    drive_ab(1'b1, 1'b0, 1'b1, 4'd1, 1'b1);
    repeat (6) tick();
    check("after_prime_step", int'(count), 1);

    // en low: two up steps are tracked but not counted; re-enable gives no step.
    en = 1'b0;
    drive_ab(1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    repeat (6) tick();
    drive_ab(1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
    repeat (6) tick();
    check("en0_count", int'(count), 1);
    en = 1'b1;
    repeat (6) tick();
    check("reen_count", int'(count), 1);
    check("reen_dir", int'(dir), 1);

    // Load on the same edge as a filtered up step (01->11): load wins.
    drive_ab(1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
    repeat (StepLat - 1) tick();
    load = 1'b1;
    load_val = 4'd9;
    tick();
    load = 1'b0;
    check("load_vs_step_count", int'(count), 9);
    check("load_vs_step_step", int'(step), 0);
    repeat (4) tick();
    check("load_hold_count", int'(count), 9);
    check("load_hold_dir", int'(dir), 1);

    // clr_err on the same edge as an illegal jump (11->00): set wins.
    drive_ab(1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    repeat (StepLat - 1) tick();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("set_wins_err", int'(err), 1);
    check("set_wins_count", int'(count), 9);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("clr_err", int'(err), 0);

    // Load alongside an illegal jump (00->11): count loads and err still sets.
    drive_ab(1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
    repeat (StepLat - 1) tick();
    load = 1'b1;
    load_val = 4'd5;
    tick();
    load = 1'b0;
    check("load_illegal_count", int'(count), 5);
    check("load_illegal_err", int'(err), 1);

    repeat (8) tick();
    check("sb_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
